// File: rtl/fifo_async_write_ptr.sv
// Write-side pointer and flag controller for the async FIFO (WCLK domain).
// Keeps binary/Gray write pointers and registered FULL/ALMOST_FULL/WCOUNT/OVERFLOW.

module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

module fifo_async_write_ptr #(
  parameter int PTR_WIDTH    = 4,
  parameter int AFULL_THRESH = 2
) (
  input  logic                 WCLK,
  input  logic                 NRST,
  input  logic                 WEN,
  input  logic [PTR_WIDTH-1:0] RPTR_G_SYNC,
  input  logic                 OVF_CLR,
  output logic                 WE_MEM,
  output logic [PTR_WIDTH-2:0] WADDR,
  output logic [PTR_WIDTH-1:0] WPTR_B,
  output logic [PTR_WIDTH-1:0] WPTR_G,
  output logic                 FULL,
  output logic                 ALMOST_FULL,
  output logic [PTR_WIDTH-1:0] WCOUNT,
  output logic                 OVERFLOW
);

  localparam int DEPTH = 1 << (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] DEPTH_V   = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(DEPTH - AFULL_THRESH);

  logic                 accept;
  logic [PTR_WIDTH-1:0] rptr_b_sync;
  logic [PTR_WIDTH-1:0] wptr_b_next;
  logic [PTR_WIDTH-1:0] wptr_g_next;
  logic [PTR_WIDTH-1:0] count_next;

  gray2bin #(.WIDTH(PTR_WIDTH)) u_rptr_g2b (
    .gray (RPTR_G_SYNC),
    .bin  (rptr_b_sync)
  );

  // Gated by the registered FULL only, so no comb path from RPTR_G_SYNC to WE_MEM.
  assign accept = WEN & ~FULL;
  assign WE_MEM = accept & NRST;
  assign WADDR  = WPTR_B[PTR_WIDTH-2:0];

  assign wptr_b_next = WPTR_B + {{(PTR_WIDTH-1){1'b0}}, accept};
  assign wptr_g_next = wptr_b_next ^ (wptr_b_next >> 1);
  assign count_next  = wptr_b_next - rptr_b_sync;

  always_ff @(posedge WCLK or negedge NRST) begin
    if (!NRST) begin
      WPTR_B      <= '0;
      WPTR_G      <= '0;
      FULL        <= 1'b0;
      ALMOST_FULL <= 1'b0;
      WCOUNT      <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      WPTR_B      <= wptr_b_next;
      WPTR_G      <= wptr_g_next;
      WCOUNT      <= count_next;
      FULL        <= (count_next == DEPTH_V);
      // free <= thresh rewritten as count >= DEPTH-thresh to avoid underflow
      ALMOST_FULL <= (count_next >= AFULL_LVL);
      if (WEN && FULL) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_async_write_ptr.sv
// Scoreboard bench for fifo_async_write_ptr: stimulus pushes expectations, monitor compares.

module tb_fifo_async_write_ptr;

  logic       WCLK;
  logic       NRST;
  logic       WEN;
  logic [3:0] RPTR_G_SYNC;
  logic       OVF_CLR;
  logic       WE_MEM;
  logic [2:0] WADDR;
  logic [3:0] WPTR_B;
  logic [3:0] WPTR_G;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] WCOUNT;
  logic       OVERFLOW;

  fifo_async_write_ptr #(.PTR_WIDTH(4), .AFULL_THRESH(2)) dut (
    .WCLK        (WCLK),
    .NRST        (NRST),
    .WEN         (WEN),
    .RPTR_G_SYNC (RPTR_G_SYNC),
    .OVF_CLR     (OVF_CLR),
    .WE_MEM      (WE_MEM),
    .WADDR       (WADDR),
    .WPTR_B      (WPTR_B),
    .WPTR_G      (WPTR_G),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .WCOUNT      (WCOUNT),
    .OVERFLOW    (OVERFLOW)
  );

  initial WCLK = 1'b0;
  always #5 WCLK = ~WCLK;

  typedef struct {
    int         kind;   // 0: normal cycle, 1: async reset pulse
    string      nm;
    logic       we;
    logic [2:0] waddr;
    logic [3:0] wb;
    logic [3:0] wg;
    logic       full;
    logic       af;
    logic [3:0] cnt;
    logic       ovf;
    logic       acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] m_wb;
  logic       m_full;
  logic       m_ovf;
  logic [3:0] cur_rg;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One write-clock cycle of stimulus: drive at negedge, push expected result of next edge.
  task automatic step(input logic wen, input logic [3:0] rg, input logic clr, input string nm);
    exp_t e;
    logic [3:0] nb;
    logic [3:0] cnt;
    @(negedge WCLK);
    WEN = wen;
    RPTR_G_SYNC = rg;
    OVF_CLR = clr;
    cur_rg = rg;
    e.kind  = 0;
    e.nm    = nm;
    e.acc   = wen & ~m_full;
    e.we    = e.acc;
    e.waddr = m_wb[2:0];
    nb      = m_wb + {3'b0, e.acc};
    cnt     = nb - g2b(rg);
    e.wb    = nb;
    e.wg    = b2g(nb);
    e.cnt   = cnt;
    e.full  = (cnt == 4'd8);
    e.af    = ((8 - int'(cnt)) <= 2);
    e.ovf   = (wen & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_wb    = nb;
    m_full  = e.full;
    m_ovf   = e.ovf;
    sb.push_back(e);
  endtask

  task automatic reset_pulse();
    exp_t e;
    @(negedge WCLK);
    WEN  = 1'b1;
    NRST = 1'b0;
    e = '{kind: 1, nm: "async_reset", we: 1'b0, waddr: 3'd0, wb: 4'd0, wg: 4'd0,
          full: 1'b0, af: 1'b0, cnt: 4'd0, ovf: 1'b0, acc: 1'b0};
    sb.push_back(e);
    m_wb = 4'd0; m_full = 1'b0; m_ovf = 1'b0;
    #4;
    WEN  = 1'b0;
    NRST = 1'b1;
  endtask

  // Monitor: comb outputs checked late in the low phase, registers just after the edge.
  initial begin : monitor
    exp_t       it;
    logic [3:0] prev_g;
    prev_g = 4'd0;
    forever begin
      @(negedge WCLK);
      #3;
      if (sb.size() == 0) continue;
      it = sb.pop_front();
      check({it.nm, ".we_mem"}, WE_MEM, it.we);
      if (it.kind == 1) begin
        check({it.nm, ".wptr_b"},   WPTR_B,      0);
        check({it.nm, ".wptr_g"},   WPTR_G,      0);
        check({it.nm, ".full"},     FULL,        0);
        check({it.nm, ".afull"},    ALMOST_FULL, 0);
        check({it.nm, ".wcount"},   WCOUNT,      0);
        check({it.nm, ".overflow"}, OVERFLOW,    0);
        prev_g = 4'd0;
        continue;
      end
      check({it.nm, ".waddr"}, WADDR, it.waddr);
      @(posedge WCLK);
      #1;
      check({it.nm, ".wptr_b"},   WPTR_B,      it.wb);
      check({it.nm, ".wptr_g"},   WPTR_G,      it.wg);
      check({it.nm, ".full"},     FULL,        it.full);
      check({it.nm, ".afull"},    ALMOST_FULL, it.af);
      check({it.nm, ".wcount"},   WCOUNT,      it.cnt);
      check({it.nm, ".overflow"}, OVERFLOW,    it.ovf);
      if (it.acc) check({it.nm, ".gray_bits_changed"}, $countones(WPTR_G ^ prev_g), 1);
      prev_g = WPTR_G;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] rg_hold;
    NRST = 1'b0; WEN = 1'b0; RPTR_G_SYNC = 4'd0; OVF_CLR = 1'b0;
    m_wb = 4'd0; m_full = 1'b0; m_ovf = 1'b0; cur_rg = 4'd0;
    repeat (3) @(negedge WCLK);
    NRST = 1'b1;

    // Partial fill to WPTR_B=5, then async reset between edges
    for (int k = 0; k < 5; k++) step(1'b1, 4'd0, 1'b0, "prefill");
    reset_pulse();

    // Fill to full, then one rejected write
    for (int k = 0; k < 8; k++) step(1'b1, 4'd0, 1'b0, "fill");
    step(1'b1, 4'd0, 1'b0, "fill_overflow");

    // Drain: read pointer jumps to binary 3
    step(1'b0, 4'b0010, 1'b0, "drain");
    step(1'b0, 4'b0010, 1'b1, "ovf_clr_idle");

    // Wrap with the read pointer trailing by three
    for (int k = 0; k < 20; k++) step(1'b1, b2g(m_wb - 4'd3), 1'b0, "wrap");

    // Refill to full with the read pointer held
    rg_hold = cur_rg;
    for (int k = 0; k < 8 && !m_full; k++) step(1'b1, rg_hold, 1'b0, "refill");

    // Race: write while full as the read pointer advances
    rg_hold = b2g(g2b(rg_hold) + 4'd1);
    step(1'b1, rg_hold, 1'b0, "race_reject");
    step(1'b1, rg_hold, 1'b0, "race_accept");

    // Set beats clear, then clear alone
    step(1'b1, rg_hold, 1'b1, "ovf_set_wins");
    step(1'b0, rg_hold, 1'b1, "ovf_clear");
    step(1'b0, rg_hold, 1'b0, "idle");

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge WCLK);
    repeat (2) @(negedge WCLK);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
